program_loader: RTL and testbench
=================================

# program_loader

Boot-time controller that sequences instruction memory loading. It takes the byte stream from the UART receiver and assembles 32-bit little-endian words. Each word is written into instruction memory through that memory's push port. When loading finishes, it acknowledges the host over the UART transmitter and raises a level that releases the CPU core to fetch. It sits between the UART pair, the instruction memory push port and the core's run/stall input.

## Interface
- INSTR_MEM_SIZE, 32'h8000: instruction memory depth in words; the largest accepted program size.
- ACK_BYTE, 8'hAA: byte transmitted to the host after the last word is pushed.

- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_busy  in  1  UART transmitter is sending; tx_start is not permitted while high.
- tx_start  out  1  one-cycle pulse: transmit tx_data.
- tx_data  out  8  byte to transmit; constant ACK_BYTE.
- push  out  1  one-cycle pulse: write push_data into instruction memory at its next sequential address.
- push_data  out  32  assembled instruction word.
- load_done  out  1  level; high once the program is loaded and acknowledged; core runs only while high.
- error  out  1  level; sticky until reset; declared size exceeded INSTR_MEM_SIZE.

## Operation
- Host protocol: 4-byte little-endian word count N, then N words, each 4 bytes little-endian (first byte = bits 7:0).
- States:
  - SIZE: collect 4 bytes into a 32-bit count register.
    - After the 4th byte: if N == 0, go to ACK.
    - If N > INSTR_MEM_SIZE, go to ERROR.
    - Otherwise load remaining = N and go to DATA.
  - DATA: shift bytes into the word register using a 2-bit byte index.
    - On the 4th byte, pulse push with the completed word, decrement remaining and wrap the index to 0.
    - When remaining reaches 0, go to ACK.
  - ACK: wait until tx_busy == 0, then pulse tx_start for one cycle and go to DONE.
  - DONE: load_done = 1. Terminal until reset.
  - ERROR: error = 1, load_done = 0. Terminal until reset. No push and no tx_start.
- rx_valid is ignored in ACK, DONE and ERROR. Extra bytes never cause a push.
- Exactly N pushes per load, in stream order. The instruction memory rewinds its write pointer on the same system reset, so push k lands at address k.
- The comparison against INSTR_MEM_SIZE is unsigned 32-bit. N == INSTR_MEM_SIZE is accepted.
- Word assembly is byte-indexed, not time-based. Arbitrary idle gaps between bytes are legal.

## Timing
- Reset values (asserted asynchronously):
  - state = SIZE; byte index = 0; count, remaining and word register = 0.
  - push = 0, push_data = 0, tx_start = 0, load_done = 0, error = 0.
  - tx_data = ACK_BYTE at all times.
- Outputs are registered. push and push_data are valid in the cycle after the edge that samples the 4th byte's rx_valid, and push is high for exactly that cycle.
- push_data holds its value until the next push.
- Last-word push and the entry to ACK take effect on the same edge. tx_start is asserted no earlier than the cycle after the last push.
- If tx_busy is low on entry to ACK, tx_start pulses in the next cycle. load_done rises the cycle after the tx_start pulse.
- ERROR is entered on the edge that samples the 4th size byte. error is visible the following cycle.
- rx_valid on consecutive cycles must be accepted without loss, sustaining 1 byte/cycle.
- Reset mid-load (any state): everything returns to SIZE immediately. The partial word and count are discarded, and a fresh size header is expected.

## Test plan
- Load N=3, words 32'h00000013, 32'hDEADBEEF, 32'h12345678 as 16 bytes with gaps -> three push pulses with those push_data values in order; one tx_start with tx_data=8'hAA; load_done=1 one cycle after tx_start.
- Send N=0 (bytes 00 00 00 00) -> no push; tx_start pulses; load_done=1.
- Send N=INSTR_MEM_SIZE+1 -> error=1, load_done=0, no push or tx_start; further bytes ignored.
- Hold tx_busy=1 for 20 cycles after the last word -> tx_start held off until the first cycle after tx_busy falls; exactly one pulse.
- Drop reset low after 2 bytes of word 2 in an N=2 load, then reload N=1, word 32'hCAFEF00D -> all outputs 0 during reset; exactly one push of 32'hCAFEF00D after reload; load_done=1.
- Back-to-back rx_valid (1 byte/cycle) for N=4 plus 4 trailing junk bytes -> four pushes, spaced exactly 4 cycles apart; junk bytes cause no push.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: boot-time loader that assembles little-endian words from the
// UART byte stream and pushes them into instruction memory. After the last
// word it sends one acknowledge byte to the host and releases the core.
// Protocol: 4-byte word count N, then N words of 4 bytes each, LSB first.
module program_loader #(
   parameter logic [31:0] INSTR_MEM_SIZE = 32'h0000_8000,
   parameter logic [7:0]  ACK_BYTE       = 8'hAA
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        push,
   output logic [31:0] push_data,
   output logic        load_done,
   output logic        error
);

   typedef enum logic [2:0] {
      ST_SIZE  = 3'd0,
      ST_DATA  = 3'd1,
      ST_ACK   = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_e;

   state_e      state_q,       state_d;
   logic [1:0]  byte_idx_q,    byte_idx_d;
   logic [31:0] count_q,       count_d;
   logic [31:0] remaining_q,   remaining_d;
   logic [31:0] word_q,        word_d;
   logic        push_q,        push_d;
   logic [31:0] push_data_q,   push_data_d;
   logic        tx_start_q,    tx_start_d;
   logic        load_done_q,   load_done_d;
   logic        error_q,       error_d;

   // Bytes arrive LSB first, so each new byte enters at the top and the
   // register shifts right; after four bytes the first byte sits in [7:0].
   // The 4th-byte decisions use these shifted values so that a full word or
   // count is acted on in the same cycle its last byte arrives.
   logic [31:0] count_shift;
   logic [31:0] word_shift;
   logic        last_byte;

   assign count_shift = {rx_data, count_q[31:8]};
   assign word_shift  = {rx_data, word_q[31:8]};
   assign last_byte   = (byte_idx_q == 2'd3);

   // The acknowledge byte never changes.
   assign tx_data   = ACK_BYTE;

   assign push      = push_q;
   assign push_data = push_data_q;
   assign tx_start  = tx_start_q;
   assign load_done = load_done_q;
   assign error     = error_q;

   // Next-state and registered-output logic for the load sequence.
   always_comb begin
      state_d     = state_q;
      byte_idx_d  = byte_idx_q;
      count_d     = count_q;
      remaining_d = remaining_q;
      word_d      = word_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      tx_start_d  = 1'b0;
      load_done_d = load_done_q;
      error_d     = error_q;

      case (state_q)
         ST_SIZE: begin
            if (rx_valid) begin
               count_d    = count_shift;
               byte_idx_d = byte_idx_q + 2'd1;
               if (last_byte) begin
                  if (count_shift == 32'd0) begin
                     state_d = ST_ACK;
                  end else if (count_shift > INSTR_MEM_SIZE) begin
                     // Raise error on the same edge so it is visible at once.
                     state_d = ST_ERROR;
                     error_d = 1'b1;
                  end else begin
                     remaining_d = count_shift;
                     state_d     = ST_DATA;
                  end
               end
            end
         end

         ST_DATA: begin
            if (rx_valid) begin
               word_d     = word_shift;
               byte_idx_d = byte_idx_q + 2'd1;
               if (last_byte) begin
                  push_d      = 1'b1;
                  push_data_d = word_shift;
                  remaining_d = remaining_q - 32'd1;
                  // remaining_q == 1 means this push is the final word.
                  if (remaining_q == 32'd1) begin
                     state_d = ST_ACK;
                  end
               end
            end
         end

         ST_ACK: begin
            // Hold the acknowledge until the transmitter is free.
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               state_d    = ST_DONE;
            end
         end

         ST_DONE: begin
            // load_done rises one cycle after the tx_start pulse.
            load_done_d = 1'b1;
         end

         ST_ERROR: begin
            error_d     = 1'b1;
            load_done_d = 1'b0;
         end

         default: begin
            state_d = ST_SIZE;
         end
      endcase
   end

   // State register; an asynchronous reset always restarts at the size header.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_SIZE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers; reset discards any partial word or count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         byte_idx_q  <= 2'd0;
         count_q     <= 32'd0;
         remaining_q <= 32'd0;
         word_q      <= 32'd0;
         push_q      <= 1'b0;
         push_data_q <= 32'd0;
         tx_start_q  <= 1'b0;
         load_done_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         byte_idx_q  <= byte_idx_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         word_q      <= word_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
         tx_start_q  <= tx_start_d;
         load_done_q <= load_done_d;
         error_q     <= error_d;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a monitor logs every push, tx_start and
// load_done rise; the stimulus sequence queues the expected words and their
// cycles and compares them against the log after each scenario.
module tb_program_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_busy = 1'b0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        push;
   logic [31:0] push_data;
   logic        load_done;
   logic        error;

   program_loader dut (
      .clock     (clock),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .push      (push),
      .push_data (push_data),
      .load_done (load_done),
      .error     (error)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Monitor log (written only here).
   logic [31:0] mon_pval[$];
   int          mon_pcyc[$];
   int          mon_tcyc[$];
   logic [7:0]  mon_tdat[$];
   int          mon_lcyc[$];
   logic        ld_prev = 1'b0;

   always @(negedge clock) begin
      if (push === 1'b1) begin
         mon_pval.push_back(push_data);
         mon_pcyc.push_back(cyc);
      end
      if (tx_start === 1'b1) begin
         mon_tcyc.push_back(cyc);
         mon_tdat.push_back(tx_data);
      end
      if (load_done === 1'b1 && ld_prev !== 1'b1) mon_lcyc.push_back(cyc);
      ld_prev = load_done;
   end

   // Scoreboard and bookkeeping (written only by the stimulus block).
   logic [31:0] exp_q[$];
   int          exp_c[$];
   int checks = 0;
   int errors = 0;
   int prd = 0;
   int trd = 0;
   int lrd = 0;
   int last_samp = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clock);
      #1;
      last_samp = cyc;
      rx_valid  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap, input bit expect_push);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8]);
         if (i != 3) idle(gap);
      end
      if (expect_push) begin
         exp_q.push_back(w);
         exp_c.push_back(last_samp);
      end
   endtask

   task automatic drain_pushes(input string tag);
      while (prd < mon_pval.size()) begin
         if (exp_q.size() == 0) begin
            chk({tag, "_extra_push"}, mon_pval[prd], 32'hxxxxxxxx);
         end else begin
            chk({tag, "_push_data"}, mon_pval[prd], exp_q.pop_front());
            chk({tag, "_push_cycle"}, mon_pcyc[prd], exp_c.pop_front());
         end
         prd++;
      end
      chk({tag, "_missing_pushes"}, exp_q.size(), 0);
      exp_q.delete();
      exp_c.delete();
   endtask

   task automatic check_tx(input string tag, input int n, input int exp_cyc);
      chk({tag, "_tx_count"}, mon_tcyc.size() - trd, n);
      if (n == 1 && mon_tcyc.size() - trd == 1) begin
         chk({tag, "_tx_cycle"}, mon_tcyc[trd], exp_cyc);
         chk({tag, "_tx_data"}, {24'd0, mon_tdat[trd]}, 32'h0000_00AA);
      end
      trd = mon_tcyc.size();
   endtask

   task automatic check_ld(input string tag, input int exp_cyc);
      chk({tag, "_ld_rise_count"}, mon_lcyc.size() - lrd, 1);
      if (mon_lcyc.size() - lrd == 1) chk({tag, "_ld_cycle"}, mon_lcyc[lrd], exp_cyc);
      lrd = mon_lcyc.size();
   endtask

   task automatic wait_done(input string tag, input int bound);
      for (int i = 0; i < bound && load_done !== 1'b1; i++) @(negedge clock);
      chk({tag, "_load_done"}, load_done, 1'b1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_push"}, push, 1'b0);
      chk({tag, "_push_data"}, push_data, 32'd0);
      chk({tag, "_tx_start"}, tx_start, 1'b0);
      chk({tag, "_load_done"}, load_done, 1'b0);
      chk({tag, "_error"}, error, 1'b0);
      chk({tag, "_tx_data"}, tx_data, 8'hAA);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clock);
      #3 reset = 1'b0;
      @(negedge clock);
      check_idle_outputs(tag);
      idle(2);
      reset = 1'b1;
      prd = mon_pval.size();
      trd = mon_tcyc.size();
      lrd = mon_lcyc.size();
   endtask

   initial begin
      int fall_cyc;
      int base;

      // Reset state.
      idle(2);
      do_reset("rst0");

      // N=3 with idle gaps between bytes.
      send_word(32'd3, 3, 1'b0);
      idle(2);
      send_word(32'h0000_0013, 2, 1'b1);
      idle(5);
      send_word(32'hDEAD_BEEF, 1, 1'b1);
      idle(3);
      send_word(32'h1234_5678, 4, 1'b1);
      base = last_samp;
      wait_done("n3", 30);
      idle(3);
      drain_pushes("n3");
      check_tx("n3", 1, base + 1);
      check_ld("n3", base + 2);
      chk("n3_error", error, 1'b0);

      // N=0: straight to acknowledge.
      do_reset("rst1");
      send_word(32'd0, 0, 1'b0);
      base = last_samp;
      wait_done("n0", 20);
      idle(3);
      drain_pushes("n0");
      check_tx("n0", 1, base + 1);
      check_ld("n0", base + 2);

      // N = INSTR_MEM_SIZE + 1: error, then junk is ignored.
      do_reset("rst2");
      send_word(32'h0000_8001, 1, 1'b0);
      @(negedge clock);
      chk("ovf_error_next_cycle", error, 1'b1);
      chk("ovf_load_done", load_done, 1'b0);
      @(posedge clock);
      #1;
      for (int i = 0; i < 8; i++) send_byte(8'h5A + 8'(i));
      idle(10);
      drain_pushes("ovf");
      check_tx("ovf", 0, 0);
      chk("ovf_error_sticky", error, 1'b1);
      chk("ovf_load_done_after", load_done, 1'b0);

      // Unsigned compare: huge N is rejected.
      do_reset("rst3");
      send_word(32'h8000_0000, 0, 1'b0);
      @(negedge clock);
      chk("big_error", error, 1'b1);

      // N == INSTR_MEM_SIZE is accepted (header only).
      do_reset("rst4");
      send_word(32'h0000_8000, 0, 1'b0);
      idle(3);
      chk("max_error", error, 1'b0);
      chk("max_load_done", load_done, 1'b0);

      // tx_busy held high across the end of the load.
      do_reset("rst5");
      tx_busy = 1'b1;
      send_word(32'd1, 0, 1'b0);
      send_word(32'h1122_3344, 1, 1'b1);
      idle(20);
      check_tx("busy_hold", 0, 0);
      chk("busy_load_done_hold", load_done, 1'b0);
      tx_busy  = 1'b0;
      fall_cyc = cyc;
      wait_done("busy", 20);
      idle(5);
      drain_pushes("busy");
      check_tx("busy", 1, fall_cyc + 1);
      check_ld("busy", fall_cyc + 2);

      // Reset in the middle of word 2, then reload N=1.
      do_reset("rst6");
      send_word(32'd2, 0, 1'b0);
      send_word(32'hA5A5_0F0F, 1, 1'b1);
      send_byte(8'h01);
      send_byte(8'h02);
      idle(2);
      drain_pushes("mid");
      do_reset("mid_rst");
      send_word(32'd1, 1, 1'b0);
      send_word(32'hCAFE_F00D, 1, 1'b1);
      base = last_samp;
      wait_done("reload", 20);
      idle(3);
      drain_pushes("reload");
      check_tx("reload", 1, base + 1);

      // Back-to-back bytes: N=4 plus 4 junk bytes.
      do_reset("rst7");
      base = mon_pcyc.size();
      send_word(32'd4, 0, 1'b0);
      send_word(32'h0102_0304, 0, 1'b1);
      send_word(32'hF0E0_D0C0, 0, 1'b1);
      send_word(32'h7777_8888, 0, 1'b1);
      send_word(32'h0BAD_CAFE, 0, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(8'hEE);
      idle(10);
      chk("b2b_push_total", mon_pcyc.size() - base, 4);
      if (mon_pcyc.size() - base == 4) begin
         for (int i = 1; i < 4; i++)
            chk("b2b_spacing", mon_pcyc[base + i] - mon_pcyc[base + i - 1], 4);
      end
      drain_pushes("b2b");
      check_tx("b2b", 1, mon_pcyc[mon_pcyc.size() - 1] + 1);
      chk("b2b_load_done", load_done, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
